// File: rtl/iadc_mc.sv
// iadc_mc: multi-channel integrating ADC with decimator, moving-average filter and valid/ready result bus.
// Define IADC_MC_PEAK_EN to add the per-channel running peak (peak_clr / peak ports).

module iadc_mc_ch #(
  parameter int ACC_W     = 12,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 6,
  parameter int TOP       = 4090,
  parameter int LPF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             comp,
  input  logic             strobe,
  output logic             sdm,
  output logic [OUT_W-1:0] avg
);
  localparam int LG    = $clog2(LPF_DEPTH);
  localparam int SUM_W = OUT_W + LG;
  localparam logic [ACC_W-1:0] TOP_V = ACC_W'(TOP);

  logic [ACC_W-1:0]                acc, inc, gap;
  logic [ACC_W:0]                  acc_sum;
  logic [LPF_DEPTH-1:0][OUT_W-1:0] taps;
  logic [SUM_W-1:0]                sum;

  // saturation can push acc past TOP; the remaining charge gap floors at zero there
  assign gap     = (acc >= TOP_V) ? '0 : TOP_V - acc;
  assign acc_sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdm  <= 1'b0;
      acc  <= '0;
      inc  <= '0;
      taps <= '0;
    end else begin
      sdm <= comp;
      inc <= (&acc) ? '0 : (gap >> SHIFT);
      if (comp) acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      else      acc <= acc - (acc >> SHIFT);
      if (strobe) begin
        taps[0] <= acc[ACC_W-1 -: OUT_W];
        for (int i = 1; i < LPF_DEPTH; i++) taps[i] <= taps[i-1];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LPF_DEPTH; i++) sum = sum + SUM_W'(taps[i]);
  end

  assign avg = OUT_W'(sum >> LG);
endmodule

module iadc_mc #(
  parameter int NCH       = 2,
  parameter int ACC_W     = 12,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 6,
  parameter int TOP       = 4090,
  parameter int DIV       = 8,
  parameter int LPF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NCH-1:0]       comp,
  output logic [NCH-1:0]       sdm,
  output logic [NCH*OUT_W-1:0] q,
  output logic                 valid,
  input  logic                 ready,
  output logic                 ovr,
  input  logic                 ovr_clr
`ifdef IADC_MC_PEAK_EN
  ,
  input  logic                 peak_clr,
  output logic [NCH*OUT_W-1:0] peak
`endif
);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]          count;
  logic                      strobe, load, overrun;
  logic [NCH-1:0][OUT_W-1:0] avg, q_r;

  assign strobe  = en && (count == CNT_LAST);
  assign overrun = load && valid && !ready;
  assign q       = q_r;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    iadc_mc_ch #(
      .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TOP(TOP), .LPF_DEPTH(LPF_DEPTH)
    ) u_ch (
      .clk(clk), .reset(reset), .comp(comp[n]), .strobe(strobe), .sdm(sdm[n]), .avg(avg[n])
    );
  end

  // load trails strobe by one edge so the filter sums the freshly shifted taps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      load  <= 1'b0;
      q_r   <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      count <= (!en || strobe) ? '0 : count + 1'b1;
      load  <= strobe;
      if (load) begin
        q_r   <= avg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (overrun)      ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;
    end
  end

`ifdef IADC_MC_PEAK_EN
  logic [NCH-1:0][OUT_W-1:0] peak_r;
  assign peak = peak_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_r <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (load) peak_r[n] <= (peak_clr || avg[n] > peak_r[n]) ? avg[n] : peak_r[n];
        else if (peak_clr) peak_r[n] <= '0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_iadc_mc.sv
// Bench for iadc_mc: randomized stimulus against an integer-arithmetic reference model.
module tb_iadc_mc;
  localparam int NCH = 2, ACC_W = 12, OUT_W = 8, SHIFT = 6, TOP = 4090, DIV = 8, LPF_DEPTH = 4;
  localparam int AMAX = (1 << ACC_W) - 1;
  localparam int VW   = 2 * NCH + NCH * OUT_W;

  logic clk = 1'b0, reset = 1'b1, en = 1'b0, ready = 1'b0, ovr_clr = 1'b0;
  logic [NCH-1:0] comp = '0;
  logic [NCH-1:0] sdm;
  logic [NCH*OUT_W-1:0] q;
  logic valid, ovr;
`ifdef IADC_MC_PEAK_EN
  logic peak_clr = 1'b0;
  logic [NCH*OUT_W-1:0] peak;
`endif

  int n_cmp = 0, n_err = 0;

  iadc_mc #(
    .NCH(NCH), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .TOP(TOP), .DIV(DIV), .LPF_DEPTH(LPF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .comp(comp), .sdm(sdm), .q(q),
    .valid(valid), .ready(ready), .ovr(ovr), .ovr_clr(ovr_clr)
`ifdef IADC_MC_PEAK_EN
    , .peak_clr(peak_clr), .peak(peak)
`endif
  );

  always #5 clk = ~clk;

  // reference model: integer state updated once per clock edge
  int m_acc[NCH], m_inc[NCH], m_q[NCH], m_peak[NCH];
  int m_taps[NCH][LPF_DEPTH];
  int m_cnt = 0;
  bit m_pend = 0, m_valid = 0, m_ovr = 0;
  logic [NCH-1:0] m_sdm = '0;
  bit md_strobe, md_load;
  int md_sum, md_nq, md_ninc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_inc[c] = 0; m_q[c] = 0; m_peak[c] = 0;
        for (int j = 0; j < LPF_DEPTH; j++) m_taps[c][j] = 0;
      end
      m_cnt = 0; m_pend = 0; m_valid = 0; m_ovr = 0; m_sdm = '0;
    end else begin
      md_load   = m_pend;
      md_strobe = en && (m_cnt == DIV - 1);
      if (md_load && m_valid && !ready) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      if (md_load) begin
        m_valid = 1;
        for (int c = 0; c < NCH; c++) begin
          md_sum = 0;
          for (int j = 0; j < LPF_DEPTH; j++) md_sum += m_taps[c][j];
          md_nq = md_sum / LPF_DEPTH;
`ifdef IADC_MC_PEAK_EN
          m_peak[c] = (peak_clr || md_nq > m_peak[c]) ? md_nq : m_peak[c];
`endif
          m_q[c] = md_nq;
        end
      end else begin
        if (m_valid && ready) m_valid = 0;
`ifdef IADC_MC_PEAK_EN
        if (peak_clr) for (int c = 0; c < NCH; c++) m_peak[c] = 0;
`endif
      end
      if (md_strobe)
        for (int c = 0; c < NCH; c++) begin
          for (int j = LPF_DEPTH - 1; j > 0; j--) m_taps[c][j] = m_taps[c][j-1];
          m_taps[c][0] = m_acc[c] / (1 << (ACC_W - OUT_W));
        end
      m_pend = md_strobe;
      m_cnt  = en ? (m_cnt + 1) % DIV : 0;
      for (int c = 0; c < NCH; c++) begin
        md_ninc = (m_acc[c] == AMAX) ? 0 : ((TOP > m_acc[c]) ? (TOP - m_acc[c]) / (1 << SHIFT) : 0);
        if (comp[c]) m_acc[c] = (m_acc[c] + m_inc[c] > AMAX) ? AMAX : m_acc[c] + m_inc[c];
        else         m_acc[c] = m_acc[c] - m_acc[c] / (1 << SHIFT);
        m_inc[c] = md_ninc;
      end
      m_sdm = comp;
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [NCH*OUT_W-1:0] eq;
    for (int c = 0; c < NCH; c++) eq[c*OUT_W +: OUT_W] = OUT_W'(m_q[c]);
    return {m_sdm, eq, m_valid, m_ovr};
  endfunction

  logic [VW-1:0] dut_vec;
  assign dut_vec = {sdm, q, valid, ovr};

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({sdm, q, valid, ovr} !== '0) begin n_err++; $display("FAIL reset_por got %h want 0", dut_vec); end
    reset = 1'b0; en = 1'b1; ready = 1'b0; comp = 2'b11;
    repeat (60) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL run_11 got %h want %h", dut_vec, exp_vec()); end
    end
    @(posedge clk); #2 reset = 1'b1; #1;
    n_cmp++;
    if ({sdm, q, valid, ovr} !== '0) begin n_err++; $display("FAIL reset_async got %h want 0", dut_vec); end
    @(negedge clk); reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL post_reset got %h want %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_zero_input();
    int last = -1;
    reset = 1'b1; @(negedge clk);
    reset = 1'b0; en = 1'b1; ready = 1'b1; comp = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL zero_model got %h want %h", dut_vec, exp_vec()); end
      n_cmp++;
      if (q !== '0) begin n_err++; $display("FAIL zero_q got %h want 0", q); end
      if (valid) begin
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != DIV) begin n_err++; $display("FAIL valid_period got %0d want %0d", cyc - last, DIV); end
        end
        last = cyc;
      end
    end
    n_cmp++;
    if (last < 0) begin n_err++; $display("FAIL zero_valid got none want pulses"); end
  endtask

  task automatic test_settle();
    int seen = 0;
    comp = 2'b01; en = 1'b1; ready = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL settle_model got %h want %h", dut_vec, exp_vec()); end
      if (cyc > 1000 && valid) begin
        seen++;
        n_cmp++;
        if (q[7:0] < 8'hFB || q[15:8] !== 8'h00)
          begin n_err++; $display("FAIL settle_range got %h want ch0 FB..FF ch1 00", q); end
      end
    end
    n_cmp++;
    if (seen == 0) begin n_err++; $display("FAIL settle_valid got none want results"); end
  endtask

  task automatic test_overrun();
    logic [VW-1:0] e;
    ready = 1'b1;
    for (int k = 0; k < 20 && m_cnt != 2; k++) begin @(negedge clk); comp = NCH'($urandom); end
    ready = 1'b0;
    repeat (2 * DIV + 2) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL ovr_model got %h want %h", dut_vec, exp_vec()); end
      comp = NCH'($urandom);
    end
    n_cmp++;
    if (valid !== 1'b1 || ovr !== 1'b1) begin n_err++; $display("FAIL ovr_hold got v%b o%b want v1 o1", valid, ovr); end
    for (int k = 0; k < 20 && m_cnt != 2; k++) @(negedge clk);
    e = exp_vec();
    n_cmp++;
    if (q !== e[VW-NCH-1:2] || m_cnt != 2) begin n_err++; $display("FAIL ovr_q got %h want %h", q, e[VW-NCH-1:2]); end
    ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin n_err++; $display("FAIL valid_drop got %b want 0", valid); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    n_cmp++;
    if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clr got %b want 0", ovr); end
  endtask

  task automatic test_enable();
    int hit = -1;
    ready = 1'b1; en = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      comp = NCH'($urandom);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL en_model got %h want %h", dut_vec, exp_vec()); end
      if (cyc >= 2) begin
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL en_low_valid got %b want 0 at %0d", valid, cyc); end
      end
    end
    @(posedge clk); #1 en = 1'b1;
    for (int k = 1; k <= 20 && hit < 0; k++) begin
      @(posedge clk); #1;
      if (valid) hit = k;
    end
    n_cmp++;
    if (hit != 9) begin n_err++; $display("FAIL en_latency got %0d want 9", hit); end
  endtask

  task automatic test_random();
    repeat (3000) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL rand_model got %h want %h", dut_vec, exp_vec()); end
      comp    = NCH'($urandom);
      en      = ($urandom_range(0, 15) != 0);
      ready   = ($urandom_range(0, 3) != 0);
      ovr_clr = ($urandom_range(0, 7) == 0);
    end
    ovr_clr = 1'b0;
  endtask

`ifdef IADC_MC_PEAK_EN
  task automatic test_peak();
    logic [NCH*OUT_W-1:0] ep;
    en = 1'b1; ready = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) ep[c*OUT_W +: OUT_W] = OUT_W'(m_peak[c]);
      n_cmp++;
      if (peak !== ep) begin n_err++; $display("FAIL peak_model got %h want %h", peak, ep); end
      comp     = NCH'($urandom);
      peak_clr = ($urandom_range(0, 63) == 0);
    end
    peak_clr = 1'b0;
    for (int k = 0; k < 20 && m_cnt != 2; k++) @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    n_cmp++;
    if (peak !== '0) begin n_err++; $display("FAIL peak_clr got %h want 0", peak); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_input();
    test_settle();
    test_overrun();
    test_enable();
    test_random();
`ifdef IADC_MC_PEAK_EN
    test_peak();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
